fifo_stream_reader: RTL and testbench

//  Read-side master for the synchronous FIFO: drains it via rd_en/empty/rdata and
//  re-presents the words as a valid/ready stream. Prefetches into a small local

---
 rtl/fifo_pkg.sv | 4 +
 rtl/stream_buf.sv | 58 +++++
 rtl/fifo_stream_reader.sv | 71 +++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO word-width constant
package fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
endpackage

// File: rtl/stream_buf.sv
// rtl/stream_buf.sv - circular register queue with push/pop, occupancy and head output
module stream_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int OCC_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occ
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (occ_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // occupancy is tracked separately so full and empty stay distinguishable
    occ_d = occ_q + OCC_W'(push) - OCC_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && occ_q == OCC_W'(DEPTH)));
endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a synchronous FIFO into a valid/ready stream with prefetch
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  words_out
);
  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int INF_W = $clog2(RD_LATENCY + 1);

  logic [RD_LATENCY-1:0] issue_q, issue_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [INF_W-1:0]      inflight;
  logic [OCC_W-1:0]      occ;
  logic                  capture;
  logic                  pop;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign idle    = (occ == '0) && (inflight == '0);
  assign capture = issue_q[RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + INF_W'(issue_q[i]);
    // words already requested count against buffer space so a capture always fits
    fifo_rd_en = !rst && enable && !fifo_empty &&
                 ((int'(occ) + int'(inflight)) < BUF_DEPTH);
    issue_d = (issue_q << 1) | RD_LATENCY'(fifo_rd_en);
    words_d = words_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
      words_q <= '0;
    end else begin
      issue_q <= issue_d;
      words_q <= words_d;
    end
  end

  assign words_out = words_q;

  stream_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_data(fifo_rdata),
    .pop      (pop),
    .head     (m_data),
    .occ      (occ)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader with a 16-deep FIFO model
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, fifo_rd_en, m_valid, m_ready, idle;
  logic [7:0]  fifo_rdata = 8'h00;
  logic [7:0]  m_data;
  logic [15:0] words_out;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .idle(idle), .words_out(words_out)
  );

  // FIFO model: not reset by rst, so the reader resumes from the next unread word
  logic [7:0] fmem [16];
  logic [3:0] frp = 4'd0, fwp = 4'd0;
  logic [4:0] fcnt = 5'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       f_rd, f_wr;

  assign fifo_empty = (fcnt == 5'd0);
  assign f_rd = fifo_rd_en && (fcnt != 5'd0);
  assign f_wr = wr_en && (fcnt < 5'd16);

  always @(posedge clk) begin
    if (f_rd) begin
      fifo_rdata <= fmem[frp];
      frp        <= frp + 4'd1;
    end
    if (f_wr) begin
      fmem[fwp] <= wr_data;
      fwp       <= fwp + 4'd1;
    end
    fcnt <= fcnt + 5'(f_wr) - 5'(f_rd);
  end

  logic [7:0] exp_q [$];
  int n_checks = 0, n_fail = 0;
  int rd_pulses = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
      if (fifo_rd_en) rd_pulses++;
      if (stall_prev) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (!(exp_q.size() == 0 && idle) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(k < 1000), 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr_done;
    int n;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_words", 32'(words_out), 0);
    check("rst_m_data", 32'(m_data), 0);
    tick();

    // 1: sixteen words drained back-to-back
    for (int i = 1; i <= 16; i++) write_word(8'(i));
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    check("t1_first_valid", 32'(m_valid), 1);
    for (int i = 0; i < 16; i++) begin
      check("t1_back_to_back", 32'(m_valid), 1);
      @(negedge clk);
    end
    check("t1_words", 32'(words_out), 16);
    check("t1_idle", 32'(idle), 1);
    check("t1_valid_low", 32'(m_valid), 0);
    tick();

    // 2: stalled consumer limits prefetch to buffer depth
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'h21 + 8'(i));
    rd_pulses = 0;
    enable = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("t2_reads", 32'(rd_pulses), 4);
    check("t2_valid", 32'(m_valid), 1);
    check("t2_head", 32'(m_data), 32'h21);
    tick();
    m_ready = 1'b1;
    drain("t2_drain");
    check("t2_words", 32'(words_out), 24);

    // 3: random writes and random ready
    wr_done = 1'b0;
    fork
      begin
        int sent = 0;
        while (sent < 200) begin
          if ($urandom_range(0, 1) == 1 && fcnt < 5'd16) begin
            write_word(8'($urandom));
            sent++;
          end else begin
            tick();
          end
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_ready = 1'b1;
    drain("t3_drain");
    check("t3_words", 32'(words_out), 224);

    // 4: enable drops the cycle after one read issue
    enable = 1'b0;
    write_word(8'h41); write_word(8'h42); write_word(8'h43);
    enable = 1'b1;
    @(negedge clk);
    check("t4_issue", 32'(fifo_rd_en), 1);
    tick();
    enable = 1'b0;
    rd_pulses = 0;
    repeat (8) tick();
    check("t4_no_reads", 32'(rd_pulses), 0);
    check("t4_words", 32'(words_out), 225);
    enable = 1'b1;
    drain("t4_drain");
    check("t4_words_final", 32'(words_out), 227);

    // 5: reset with three words buffered
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'h51 + 8'(i));
    enable = 1'b1;
    repeat (8) tick();
    enable = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(fcnt); i++) exp_q.push_back(fmem[4'(int'(frp) + i)]);
    @(negedge clk);
    check("t5_valid", 32'(m_valid), 0);
    check("t5_rd_en", 32'(fifo_rd_en), 0);
    check("t5_idle", 32'(idle), 1);
    check("t5_words", 32'(words_out), 0);
    check("t5_fifo_left", 32'(fcnt), 4);
    tick();
    enable = 1'b1; m_ready = 1'b1;
    drain("t5_drain");
    check("t5_words_final", 32'(words_out), 4);

    // 6: single word into an empty FIFO
    rd_pulses = 0;
    write_word(8'h66);
    @(negedge clk);
    check("t6_not_empty", 32'(fifo_empty), 0);
    check("t6_rd_en", 32'(fifo_rd_en), 1);
    n = 0;
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    check("t6_latency", 32'(n), 2);
    tick();
    drain("t6_drain");
    check("t6_words", 32'(words_out), 5);
    check("t6_reads", 32'(rd_pulses), 1);
    check("sb_empty_end", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
